// File: rtl/tq_butterfly3_pipe.sv
// ---------------------------------------------------------------------------
// tq_butterfly3_pipe
//
// Registered third butterfly stage of the forward transform datapath. Each
// beat carries 32 signed 28-bit lanes. For every N-point segment (N set by
// the transform size) the stage forms sum/difference pairs; 4x4 and inverse
// beats pass unchanged. Transform size and the inverse flag are latched per
// block, and first/last-of-block flags are generated here so downstream
// stages need no beat counters. Latency is 2 cycles, throughput 1 beat/cycle.
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   i_valid     input beat valid
//   inverse     1 = inverse path (butterfly bypassed)
//   i_transize  00=4x4, 01=8x8, 10=16x16, 11=32x32
//   i_data      lane k at [28k+27:28k], signed
//   o_valid     output beat valid
//   o_inverse   inverse flag of the block this beat belongs to
//   o_transize  transform size of the block this beat belongs to
//   o_first     first beat of a block
//   o_last      last beat of a block
//   o_data      result lanes, same packing as i_data
//
// Configuration
//   TQ_BUTTERFLY3_SAT_EN  defined: results saturate to [-2^27, 2^27-1]
//                         undefined: results wrap (truncate to 28 bits)
// ---------------------------------------------------------------------------
module tq_butterfly3_pipe #(
    localparam int LANES = 32,
    localparam int W     = 28
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_valid,
    input  logic               inverse,
    input  logic [1:0]         i_transize,
    input  logic [LANES*W-1:0] i_data,
    output logic               o_valid,
    output logic               o_inverse,
    output logic [1:0]         o_transize,
    output logic               o_first,
    output logic               o_last,
    output logic [LANES*W-1:0] o_data
);

`ifdef TQ_BUTTERFLY3_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    // Reduce a 29-bit sum/difference to lane width: clamp or wrap.
    function automatic logic [W-1:0] reduce(input logic [W:0] v);
        if (SAT_EN && (v[W] != v[W-1]))
            reduce = v[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        else
            reduce = v[W-1:0];
    endfunction

    // ------------------------------------------------------------------
    // Block tracking: beat counter and per-block control latch
    // ------------------------------------------------------------------
    logic [4:0] cnt;
    logic       blk_inverse;
    logic [1:0] blk_transize;

    logic       is_first;
    logic       is_last;
    logic       eff_inverse;
    logic [1:0] eff_transize;
    logic [4:0] last_idx;

    // On the first beat of a block the port values apply directly; later
    // beats use the values latched on that first beat.
    always_comb begin
        is_first     = (cnt == 5'd0);
        eff_inverse  = is_first ? inverse    : blk_inverse;
        eff_transize = is_first ? i_transize : blk_transize;
        case (eff_transize)
            2'b00:   last_idx = 5'd0;
            2'b01:   last_idx = 5'd1;
            2'b10:   last_idx = 5'd7;
            default: last_idx = 5'd31;
        endcase
        is_last = (cnt == last_idx);
    end

    // ------------------------------------------------------------------
    // Stage 1: capture lanes, block controls and first/last flags
    // ------------------------------------------------------------------
    logic               s1_valid;
    logic               s1_inverse;
    logic [1:0]         s1_transize;
    logic               s1_first;
    logic               s1_last;
    logic [LANES*W-1:0] s1_data;

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt          <= 5'd0;
            blk_inverse  <= 1'b0;
            blk_transize <= 2'b00;
            s1_valid     <= 1'b0;
            s1_inverse   <= 1'b0;
            s1_transize  <= 2'b00;
            s1_first     <= 1'b0;
            s1_last      <= 1'b0;
        end else begin
            s1_valid <= i_valid;
            if (i_valid) begin
                cnt <= is_last ? 5'd0 : cnt + 5'd1;
                if (is_first) begin
                    blk_inverse  <= inverse;
                    blk_transize <= i_transize;
                end
                s1_inverse  <= eff_inverse;
                s1_transize <= eff_transize;
                s1_first    <= is_first;
                s1_last     <= is_last;
            end
        end
    end

    // NOTE: the wide stage-1 lane register is deliberately not reset; it is
    // only ever consumed when s1_valid is set, which is reset.
    always_ff @(posedge clk) begin
        if (i_valid)
            s1_data <= i_data;
    end

    // ------------------------------------------------------------------
    // Butterfly: lane j pairs with j ^ (N-1) inside its segment; the lower
    // half of a segment takes the sum, the upper half the difference.
    // ------------------------------------------------------------------
    logic [4:0]         seg_mask;
    logic [4:0]         half_bit;
    logic [LANES*W-1:0] bf_data;

    always_comb begin
        case (s1_transize)
            2'b01:   begin seg_mask = 5'd7;  half_bit = 5'd4;  end
            2'b10:   begin seg_mask = 5'd15; half_bit = 5'd8;  end
            2'b11:   begin seg_mask = 5'd31; half_bit = 5'd16; end
            default: begin seg_mask = 5'd0;  half_bit = 5'd0;  end
        endcase
    end

    always_comb begin : bf_comb
        logic [4:0]   lane_idx;
        logic [4:0]   partner;
        logic [W-1:0] self_v;
        logic [W-1:0] peer_v;
        logic [W:0]   wide;
        bf_data  = s1_data;
        lane_idx = 5'd0;
        partner  = 5'd0;
        self_v   = '0;
        peer_v   = '0;
        wide     = '0;
        if (!s1_inverse && (s1_transize != 2'b00)) begin
            for (int j = 0; j < LANES; j++) begin
                lane_idx = 5'(j);
                partner  = lane_idx ^ seg_mask;
                self_v   = s1_data[W*j +: W];
                peer_v   = s1_data[W*partner +: W];
                if ((lane_idx & half_bit) == 5'd0)
                    wide = {self_v[W-1], self_v} + {peer_v[W-1], peer_v};
                else
                    wide = {peer_v[W-1], peer_v} - {self_v[W-1], self_v};
                bf_data[W*j +: W] = reduce(wide);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: output registers; payload holds while no beat is present
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            o_valid    <= 1'b0;
            o_inverse  <= 1'b0;
            o_transize <= 2'b00;
            o_first    <= 1'b0;
            o_last     <= 1'b0;
            o_data     <= '0;
        end else begin
            o_valid <= s1_valid;
            if (s1_valid) begin
                o_inverse  <= s1_inverse;
                o_transize <= s1_transize;
                o_first    <= s1_first;
                o_last     <= s1_last;
                o_data     <= bf_data;
            end
        end
    end

endmodule

// File: tb/tb_tq_butterfly3_pipe.sv
// ---------------------------------------------------------------------------
// tb_tq_butterfly3_pipe
//
// Directed self-checking bench for tq_butterfly3_pipe. Stimulus pushes a
// hand-computed expectation (due cycle, flags, selected lane values) for
// every beat that must emerge; a negedge monitor pops and compares them.
// Define TQ_BUTTERFLY3_SAT_EN for both RTL and bench to check the
// saturating build.
// ---------------------------------------------------------------------------
module tb_tq_butterfly3_pipe;

    localparam int LANES = 32;
    localparam int W     = 28;

`ifdef TQ_BUTTERFLY3_SAT_EN
    localparam int OVF_POS = 134217727;   // 2^27-1
    localparam int OVF_NEG = -134217728;  // -2^27
`else
    localparam int OVF_POS = -2;          // 2^28-2 wrapped to 28 bits
    localparam int OVF_NEG = 0;           // -2^28 wrapped to 28 bits
`endif

    logic               clk;
    logic               rst;
    logic               i_valid;
    logic               inverse;
    logic [1:0]         i_transize;
    logic [LANES*W-1:0] i_data;
    logic               o_valid;
    logic               o_inverse;
    logic [1:0]         o_transize;
    logic               o_first;
    logic               o_last;
    logic [LANES*W-1:0] o_data;

    tq_butterfly3_pipe dut (
        .clk        (clk),
        .rst        (rst),
        .i_valid    (i_valid),
        .inverse    (inverse),
        .i_transize (i_transize),
        .i_data     (i_data),
        .o_valid    (o_valid),
        .o_inverse  (o_inverse),
        .o_transize (o_transize),
        .o_first    (o_first),
        .o_last     (o_last),
        .o_data     (o_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        int                 due;
        int                 tnum;
        logic               first;
        logic               last;
        logic               inv;
        logic [1:0]         size;
        logic [LANES-1:0]   chk;
        logic [LANES*W-1:0] val;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t mk(input int tnum, input logic first, input logic last,
                                input logic inv, input logic [1:0] size);
        exp_t e;
        e       = '0;
        e.due   = cyc + 2;
        e.tnum  = tnum;
        e.first = first;
        e.last  = last;
        e.inv   = inv;
        e.size  = size;
        return e;
    endfunction

    task automatic add(inout exp_t e, input int lane, input int v);
        e.chk[lane]          = 1'b1;
        e.val[W*lane +: W]   = W'(v);
    endtask

    function automatic logic [LANES*W-1:0] ramp(input int mul);
        logic [LANES*W-1:0] v;
        v = '0;
        for (int k = 0; k < LANES; k++) v[W*k +: W] = W'(k * mul);
        return v;
    endfunction

    // Drive one cycle of inputs, then advance to the next negedge.
    task automatic drive(input logic v, input logic inv, input logic [1:0] sz,
                         input logic [LANES*W-1:0] d);
        i_valid    = v;
        inverse    = inv;
        i_transize = sz;
        i_data     = d;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 2'b00, '0);
    endtask

    // Output monitor
    always @(negedge clk) begin
        exp_t e;
        if (o_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check($sformatf("t%0d_latency", e.tnum), cyc, e.due);
                check($sformatf("t%0d_first", e.tnum), int'(o_first), int'(e.first));
                check($sformatf("t%0d_last", e.tnum), int'(o_last), int'(e.last));
                check($sformatf("t%0d_inverse", e.tnum), int'(o_inverse), int'(e.inv));
                check($sformatf("t%0d_transize", e.tnum), int'(o_transize), int'(e.size));
                for (int k = 0; k < LANES; k++) begin
                    if (e.chk[k])
                        check($sformatf("t%0d_lane%0d", e.tnum, k),
                              int'($signed(o_data[W*k +: W])),
                              int'($signed(e.val[W*k +: W])));
                end
            end
        end
    end

    initial begin
        exp_t e;
        logic [LANES*W-1:0] ovf;

        // 1: reset with valid high, then idle
        rst = 1'b1;
        i_valid = 1'b1; inverse = 1'b1; i_transize = 2'b11; i_data = ramp(5);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t1_rst_valid", int'(o_valid), 0);
            check("t1_rst_flags", int'({o_first, o_last, o_inverse}), 0);
            check("t1_rst_transize", int'(o_transize), 0);
            check("t1_rst_data_zero", int'(o_data == '0), 1);
        end
        rst = 1'b0;
        idle(3);
        check("t1_idle_valid", int'(o_valid), 0);

        // 2: 8x8 forward, 2 beats, lane k = k
        for (int b = 0; b < 2; b++) begin
            e = mk(2, b == 0, b == 1, 1'b0, 2'b01);
            add(e, 0, 7);  add(e, 7, -7); add(e, 3, 7);
            add(e, 4, -1); add(e, 8, 23); add(e, 15, -7);
            exp_q.push_back(e);
            drive(1'b1, 1'b0, 2'b01, ramp(1));
            if (b == 0) check("t2_no_early_valid", int'(o_valid), 0);
        end
        idle(3);

        // 3: inverse bypass, 32x32, lane k = -k; ports changed after beat 1
        for (int b = 0; b < 32; b++) begin
            e = mk(3, b == 0, b == 31, 1'b1, 2'b11);
            for (int k = 0; k < LANES; k++) add(e, k, -k);
            exp_q.push_back(e);
            drive(1'b1, b == 0, (b == 0) ? 2'b11 : 2'b00, ramp(-1));
        end
        idle(3);

        // 4: overflow at both rails, 16x16 forward
        ovf = '0;
        ovf[W*0  +: W] = W'(134217727);
        ovf[W*15 +: W] = W'(134217727);
        ovf[W*1  +: W] = W'(-134217728);
        ovf[W*14 +: W] = W'(-134217728);
        for (int b = 0; b < 8; b++) begin
            e = mk(4, b == 0, b == 7, 1'b0, 2'b10);
            add(e, 0, OVF_POS); add(e, 15, 0);
            add(e, 1, OVF_NEG); add(e, 14, 0);
            exp_q.push_back(e);
            drive(1'b1, 1'b0, 2'b10, ovf);
        end
        idle(3);

        // 5: mid-block size change and valid gap; then an 8x8 block
        for (int b = 0; b < 8; b++) begin
            e = mk(5, b == 0, b == 7, 1'b0, 2'b10);
            add(e, 0, 15);  add(e, 7, 15);  add(e, 8, -1);
            add(e, 15, -15); add(e, 16, 47); add(e, 31, -15);
            exp_q.push_back(e);
            drive(1'b1, 1'b0, (b < 4) ? 2'b10 : 2'b01, ramp(1));
            if (b == 3) idle(3);
        end
        for (int b = 0; b < 2; b++) begin
            e = mk(5, b == 0, b == 1, 1'b0, 2'b01);
            add(e, 0, 7); add(e, 8, 23); add(e, 15, -7);
            exp_q.push_back(e);
            drive(1'b1, 1'b0, 2'b01, ramp(1));
        end
        idle(3);

        // 6: reset after beat 10 of a 32x32 block; beat 10 is still in
        // flight when reset hits and must never emerge
        for (int b = 0; b < 10; b++) begin
            if (b < 9) begin
                e = mk(6, b == 0, 1'b0, 1'b0, 2'b11);
                add(e, 0, 31); add(e, 31, -31); add(e, 15, 31); add(e, 16, -1);
                exp_q.push_back(e);
            end
            drive(1'b1, 1'b0, 2'b11, ramp(1));
        end
        rst = 1'b1;
        idle(2);
        check("t6_rst_valid", int'(o_valid), 0);
        rst = 1'b0;
        e = mk(6, 1'b1, 1'b1, 1'b0, 2'b00);
        for (int k = 0; k < LANES; k++) add(e, k, 3 * k);
        exp_q.push_back(e);
        drive(1'b1, 1'b0, 2'b00, ramp(3));
        idle(1);

        // Drain with a bounded wait
        for (int t = 0; t < 20 && exp_q.size() != 0; t++) @(negedge clk);
        check("drain_pending_beats", exp_q.size(), 0);
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
